// File: rtl/dmem_mmio_responder_if.sv
// rtl/dmem_mmio_responder_if.sv - data-side bus between single-cycle core and memory responder
interface dmem_mmio_responder_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite,
    output aluout,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  aluout,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - word RAM plus LED, timer and 8N1 serial transmitter MMIO page
module dmem_mmio_responder #(
  parameter int DEPTH        = 64,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  dmem_mmio_responder_if.slave        bus,
  output logic [15:0]                 o_leds,
  output logic                        o_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  logic [31:0]   r_ram [DEPTH];
  logic [15:0]   r_leds;
  logic [31:0]   r_timer;
  logic          r_overrun;
  tx_state_t     r_state;
  tx_state_t     w_next_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic          w_busy;
  logic          w_tx;
  logic          w_baud_done;
  logic          w_sel_ram;
  logic          w_sel_led;
  logic          w_sel_timer;
  logic          w_sel_txdata;
  logic          w_sel_txstat;
  logic          w_wr_txdata;
  logic          w_tx_accept;
  logic [AW-1:0] w_ram_idx;
  logic          w_unused_lsbs;

  // Word access only: the byte-lane bits never influence decode or data.
  assign w_unused_lsbs = ^bus.aluout[1:0];

  assign w_ram_idx    = bus.aluout[AW+1:2];
  assign w_sel_ram    = (bus.aluout[31:16] == 16'h0) && ((bus.aluout >> (AW + 2)) == 32'h0);
  assign w_sel_led    = (bus.aluout[31:2] == 30'h3FFF_C000);
  assign w_sel_timer  = (bus.aluout[31:2] == 30'h3FFF_C001);
  assign w_sel_txdata = (bus.aluout[31:2] == 30'h3FFF_C002);
  assign w_sel_txstat = (bus.aluout[31:2] == 30'h3FFF_C003);

  assign w_wr_txdata  = bus.memwrite && w_sel_txdata;
  assign w_tx_accept  = w_wr_txdata && (r_state == S_IDLE);
  assign w_baud_done  = (r_baud == BAUD_LAST);

  // RAM write port; deliberately outside reset so contents survive it.
  always_ff @(posedge i_clk) begin
    if (bus.memwrite && w_sel_ram) begin
      r_ram[w_ram_idx] <= bus.writedata;
    end
  end

  // LED register, timer and sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_leds    <= 16'h0;
      r_timer   <= 32'h0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.memwrite && w_sel_led) begin
        r_leds <= bus.writedata[15:0];
      end
      if (bus.memwrite && w_sel_timer) begin
        r_timer <= 32'h0;
      end else begin
        r_timer <= r_timer + 32'h1;
      end
      if (bus.memwrite && w_sel_txstat) begin
        r_overrun <= 1'b0;
      end else if (w_wr_txdata && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // TX state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // TX baud/bit counters and shift register; baud restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h0;
    end else begin
      if (r_state == S_IDLE || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if (w_tx_accept) begin
        r_shift <= bus.writedata[7:0];
        r_bit   <= 3'd0;
      end else if (r_state == S_DATA && w_baud_done) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  // TX next-state decision.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_tx_accept) w_next_state = S_START;
      S_START: if (w_baud_done) w_next_state = S_DATA;
      S_DATA:  if (w_baud_done && r_bit == 3'd7) w_next_state = S_STOP;
      S_STOP:  if (w_baud_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // TX line level and busy flag, decoded from state.
  always_comb begin
    w_tx   = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE:  begin w_tx = 1'b1; w_busy = 1'b0; end
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_shift[0];
      S_STOP:  w_tx = 1'b1;
      default: begin w_tx = 1'b1; w_busy = 1'b0; end
    endcase
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    bus.readdata = 32'h0;
    if (w_sel_ram) begin
      bus.readdata = r_ram[w_ram_idx];
    end else if (w_sel_led) begin
      bus.readdata = {16'h0, r_leds};
    end else if (w_sel_timer) begin
      bus.readdata = r_timer;
    end else if (w_sel_txstat) begin
      bus.readdata = {30'h0, r_overrun, w_busy};
    end
  end

  assign o_leds = r_leds;
  assign o_tx   = w_tx;
endmodule
